grid_cell_memory: RTL and testbench

GRID_CELL_MEMORY -- requirements
Module: grid_cell_memory

---
 rtl/grid_pkg.sv | 23 ++
 rtl/grid_cell_ram.sv | 28 ++
 rtl/grid_cell_memory.sv | 137 +++++++++++++
 tb/tb_grid_cell_memory.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared grid constants, cell codes and FSM encoding for the cell memory and the grid writer.
package grid_pkg;

    localparam int GRID_W  = 32;
    localparam int GRID_H  = 24;
    localparam int CELL_PX = 32;

    localparam logic [3:0] CELL_NULL  = 4'b0000;
    localparam logic [3:0] CELL_SNAKE = 4'b0001;
    localparam logic [3:0] CELL_ROCK  = 4'b0010;
    localparam logic [3:0] CELL_SNACK = 4'b0100;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } grid_state_e;

    // Storage is laid out row-major with a fixed 32-cell row pitch.
    function automatic logic [9:0] cell_idx(input logic [15:0] x, input logic [15:0] y);
        return {y[4:0], x[4:0]};
    endfunction

endpackage

// File: rtl/grid_cell_ram.sv
// Cell storage: one synchronous write port, two combinational read ports, one registered pixel port.
module grid_cell_ram (
    input  logic       clk,
    input  logic       we_i,
    input  logic [9:0] waddr_i,
    input  logic [3:0] wdata_i,
    input  logic [9:0] ra_addr_i,
    output logic [3:0] ra_data_o,
    input  logic [9:0] ob_addr_i,
    output logic [3:0] ob_data_o,
    input  logic [9:0] px_addr_i,
    output logic [3:0] px_data_o
);

    // No reset: the clear sweep initialises every visible cell.
    logic [3:0] mem [1024];
    logic [3:0] px_q;

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        px_q <= mem[px_addr_i];
    end

    assign ra_data_o = mem[ra_addr_i];
    assign ob_data_o = mem[ob_addr_i];
    assign px_data_o = px_q;

endmodule

// File: rtl/grid_cell_memory.sv
// Game grid cell memory with clear sweep, CPU-side read port, pixel lookup and snack counter.
module grid_cell_memory #(
    parameter int GRID_W  = grid_pkg::GRID_W,
    parameter int GRID_H  = grid_pkg::GRID_H,
    parameter int CELL_PX = grid_pkg::CELL_PX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [35:0] wr_req,
    input  logic [31:0] rd_addr,
    output logic [3:0]  rd_data,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    output logic [3:0]  pix_cell,
    output logic        busy,
    output logic [9:0]  snack_count
);
    import grid_pkg::*;

    localparam int          N_CELLS = GRID_W * GRID_H;
    localparam logic [15:0] GW      = 16'(GRID_W);
    localparam logic [15:0] GH      = 16'(GRID_H);
    localparam logic [9:0]  LAST    = 10'(N_CELLS - 1);
    localparam logic [9:0]  CNT_MAX = 10'(N_CELLS);
    localparam logic [10:0] PX_DIV  = 11'(CELL_PX);
    localparam logic [10:0] PX_W    = 11'(GRID_W * CELL_PX);
    localparam logic [10:0] PX_H    = 11'(GRID_H * CELL_PX);

    grid_state_e state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  snack_q, snack_d;
    logic        pix_kill_q;

    logic [15:0] wr_x, wr_y, rd_x, rd_y;
    logic [3:0]  wr_code, old_code, ra_data, px_data;
    logic        wr_inr, rd_inr, pix_oob, wr_acc, sweep_we;
    logic        ram_we;
    logic [9:0]  ram_waddr, wr_idx;
    logic [3:0]  ram_wdata;

    assign wr_x    = wr_req[35:20];
    assign wr_y    = wr_req[19:4];
    assign wr_code = wr_req[3:0];
    assign rd_x    = rd_addr[31:16];
    assign rd_y    = rd_addr[15:0];
    assign wr_inr  = (wr_x < GW) && (wr_y < GH);
    assign rd_inr  = (rd_x < GW) && (rd_y < GH);
    assign pix_oob = (pix_x >= PX_W) || (pix_y >= PX_H);
    assign wr_idx  = cell_idx(wr_x, wr_y);

    // clear takes priority over both the sweep and any user write in the same cycle
    assign wr_acc   = (state_q == ST_IDLE) && !clear && wr_inr;
    assign sweep_we = (state_q == ST_CLEAR) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy = 1'b1;
                if (clear) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign ram_we    = sweep_we || wr_acc;
    assign ram_waddr = sweep_we ? cnt_q : wr_idx;
    assign ram_wdata = sweep_we ? CELL_NULL : wr_code;

    grid_cell_ram u_ram (
        .clk       (clk),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .ra_addr_i (cell_idx(rd_x, rd_y)),
        .ra_data_o (ra_data),
        .ob_addr_i (wr_idx),
        .ob_data_o (old_code),
        .px_addr_i (cell_idx(16'(pix_x / PX_DIV), 16'(pix_y / PX_DIV))),
        .px_data_o (px_data)
    );

    assign rd_data = !rd_inr ? CELL_ROCK : (busy ? CELL_NULL : ra_data);

    always_comb begin
        snack_d = snack_q;
        if (clear) begin
            snack_d = '0;
        end else if (wr_acc) begin
            if (wr_code == CELL_SNACK && old_code != CELL_SNACK && snack_q != CNT_MAX)
                snack_d = snack_q + 10'd1;
            else if (old_code == CELL_SNACK && wr_code != CELL_SNACK && snack_q != '0)
                snack_d = snack_q - 10'd1;
        end
    end

    // Kill flag travels alongside the registered pixel read so both line up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snack_q    <= '0;
            pix_kill_q <= 1'b1;
        end else begin
            snack_q    <= snack_d;
            pix_kill_q <= pix_oob || busy;
        end
    end

    assign pix_cell    = pix_kill_q ? CELL_NULL : px_data;
    assign snack_count = snack_q;

endmodule

// File: tb/tb_grid_cell_memory.sv
// Directed bench for grid_cell_memory with a queue scoreboard of expected values.
module tb_grid_cell_memory;

    localparam logic [35:0] WIDLE = {16'hFFFF, 16'hFFFF, 4'h0};

    logic        clk = 1'b0;
    logic        rst, clear;
    logic [35:0] wr_req;
    logic [31:0] rd_addr;
    logic [3:0]  rd_data, pix_cell;
    logic [10:0] pix_x, pix_y;
    logic        busy;
    logic [9:0]  snack_count;

    always #5 clk = ~clk;

    grid_cell_memory dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .wr_req      (wr_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_cell    (pix_cell),
        .busy        (busy),
        .snack_count (snack_count)
    );

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  ntest = 0;
    int  nfail = 0;
    int  n;

    task automatic push(input string t, input logic [9:0] e);
        sb_t s;
        s.tag = t;
        s.exp = e;
        sbq.push_back(s);
    endtask

    task automatic pop_chk(input logic [9:0] obs);
        sb_t s;
        ntest++;
        if (sbq.size() == 0) begin
            nfail++;
            $error("FAIL sb_empty observed=%0h expected=<entry>", obs);
            return;
        end
        s = sbq.pop_front();
        assert (obs === s.exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", s.tag, obs, s.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] x, input logic [15:0] y, input logic [3:0] c);
        wr_req = {x, y, c};
        tick();
        wr_req = WIDLE;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; wr_req = WIDLE; rd_addr = '0; pix_x = '0; pix_y = '0;
        tick(); tick();
        push("rst_busy", 10'd1); push("rst_pix", 10'd0); push("rst_snack", 10'd0);
        smp(); pop_chk(10'(busy)); pop_chk(10'(pix_cell)); pop_chk(snack_count);

        tick(); rst = 1'b0;
        push("sweep_len", 10'd768);
        count_busy(n); pop_chk(10'(n));

        tick(); rd_addr = {16'd3, 16'd3};
        push("rd_3_3", 10'd0); smp(); pop_chk(10'(rd_data));

        // read-first then visible next cycle
        tick(); rd_addr = {16'd15, 16'd15}; wr_req = {16'd15, 16'd15, 4'b0001};
        push("rd_first", 10'd0); smp(); pop_chk(10'(rd_data));
        tick(); wr_req = WIDLE; pix_x = 11'd490; pix_y = 11'd490;
        push("rd_15_15", 10'd1); smp(); pop_chk(10'(rd_data));
        tick(); push("pix_490", 10'd1); smp(); pop_chk(10'(pix_cell));

        // grid corner cells and pixel boundaries
        tick(); wr(16'd31, 16'd23, 4'h7); wr(16'd0, 16'd23, 4'h9);
        rd_addr = {16'd31, 16'd23}; pix_x = 11'd1023; pix_y = 11'd767;
        push("rd_31_23", 10'd7); smp(); pop_chk(10'(rd_data));
        tick(); pix_x = 11'd1024;
        push("pix_1023_767", 10'd7); smp(); pop_chk(10'(pix_cell));
        tick(); pix_x = 11'd0; pix_y = 11'd768;
        push("pix_x_oob", 10'd0); smp(); pop_chk(10'(pix_cell));
        tick(); pix_y = 11'd767;
        push("pix_y_oob", 10'd0); smp(); pop_chk(10'(pix_cell));
        tick();
        push("pix_0_767", 10'd9); smp(); pop_chk(10'(pix_cell));

        // out-of-range reads and writes
        tick(); rd_addr = {16'd32, 16'd5};
        push("rd_x32", 10'd2); smp(); pop_chk(10'(rd_data));
        tick(); rd_addr = {16'd0, 16'd24};
        push("rd_y24", 10'd2); smp(); pop_chk(10'(rd_data));
        tick(); rd_addr = {16'h0103, 16'd3};
        push("rd_xhi", 10'd2); smp(); pop_chk(10'(rd_data));
        tick(); wr(16'd40, 16'd5, 4'b0001); wr(16'h0103, 16'd3, 4'b0001);
        rd_addr = {16'd8, 16'd5};
        push("wr_x40_drop", 10'd0); smp(); pop_chk(10'(rd_data));
        tick(); rd_addr = {16'd3, 16'd3};
        push("wr_xhi_drop", 10'd0); smp(); pop_chk(10'(rd_data));

        // snack counting
        tick(); wr(16'd4, 16'd7, 4'b0100);
        push("snack_1", 10'd1); smp(); pop_chk(snack_count);
        tick(); wr(16'd4, 16'd7, 4'b0100);
        push("snack_rep", 10'd1); smp(); pop_chk(snack_count);
        tick(); wr(16'd4, 16'd7, 4'b0001);
        push("snack_0", 10'd0); smp(); pop_chk(snack_count);
        tick(); wr(16'd4, 16'd7, 4'b0001);
        push("snack_floor", 10'd0); smp(); pop_chk(snack_count);

        // clear from IDLE, behaviour while busy, then restart mid-sweep
        tick(); wr(16'd4, 16'd7, 4'b0100);
        clear = 1'b1; wr_req = {16'd2, 16'd2, 4'b0100};
        tick(); clear = 1'b0; wr_req = WIDLE;
        rd_addr = {16'd15, 16'd15}; pix_x = 11'd490; pix_y = 11'd490;
        push("clr_snack", 10'd0); push("clr_busy", 10'd1); push("busy_rd_null", 10'd0);
        smp(); pop_chk(snack_count); pop_chk(10'(busy)); pop_chk(10'(rd_data));
        tick(); rd_addr = {16'd32, 16'd0};
        push("busy_pix", 10'd0); push("busy_rd_rock", 10'd2);
        smp(); pop_chk(10'(pix_cell)); pop_chk(10'(rd_data));
        repeat (297) tick();
        clear = 1'b1; wr_req = {16'd1, 16'd1, 4'b0100};
        tick(); clear = 1'b0; wr_req = WIDLE;
        push("restart_len", 10'd768);
        count_busy(n); pop_chk(10'(n));

        tick(); rd_addr = {16'd1, 16'd1};
        push("rst_wr_drop", 10'd0); push("final_snack", 10'd0);
        smp(); pop_chk(10'(rd_data)); pop_chk(snack_count);
        tick(); rd_addr = {16'd2, 16'd2};
        push("clr_wr_drop", 10'd0); smp(); pop_chk(10'(rd_data));
        tick(); rd_addr = {16'd31, 16'd23};
        push("swept_31_23", 10'd0); smp(); pop_chk(10'(rd_data));

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
